// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment scanner.
// Segment codes are active-high gfedcba. Polarity inversion happens in seg_scan.
package seg_pkg;

    localparam logic [15:0][6:0] SEG_CODE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [7:0] seg_off(input bit act_low);
        return act_low ? 8'hFF : 8'h00;
    endfunction

    function automatic logic [7:0] sel_off(input bit act_low);
        return act_low ? 8'hFF : 8'h00;
    endfunction

    function automatic int seg_scan_div(input int clk_freq, input int scan_hz);
        return clk_freq / scan_hz;
    endfunction

endpackage

// File: rtl/seg_dec.sv
// Combinational nibble to active-high gfedcba segment code.
module seg_dec
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] code
);
    assign code = SEG_CODE[nib];
endmodule

// File: rtl/seg_scan.sv
// Eight-digit multiplexed seven-segment driver with a per-frame input snapshot.
// Define SEG_SCAN_LZB_EN to blank leading zero digits (digit 0 always shown).
module seg_scan
    import seg_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int SCAN_HZ     = 1000,
    parameter int SEL_ACT_LOW = 1,
    parameter int SEG_ACT_LOW = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] din,
    input  logic [7:0]  dot,
    output logic [7:0]  sel,
    output logic [7:0]  seg
);
    localparam int SCAN_DIV = seg_scan_div(CLK_FREQ, SCAN_HZ);
    localparam int CW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam bit SEL_LOW  = (SEL_ACT_LOW != 0);
    localparam bit SEG_LOW  = (SEG_ACT_LOW != 0);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [31:0]   frame;
    logic [7:0]    frame_dot;
    logic          load_pend;

    logic          tick;
    logic          snap;
    logic [31:0]   cur_frame;
    logic [7:0]    cur_dot;
    logic [3:0]    nib;
    logic [6:0]    code;
    logic          blank;
    logic [7:0]    seg_hi;
    logic [7:0]    sel_hi;

    assign tick = (cnt == CW'(SCAN_DIV - 1));
    assign snap = (tick && idx == 3'd7) || load_pend;

    // The first post-reset clock decodes the live input so digit 0 is valid immediately.
    assign cur_frame = load_pend ? din : frame;
    assign cur_dot   = load_pend ? dot : frame_dot;
    assign nib       = cur_frame[{idx, 2'b00} +: 4];

    seg_dec u_dec (
        .nib  (nib),
        .code (code)
    );

`ifdef SEG_SCAN_LZB_EN
    logic [7:0] lz;
    always_comb begin
        lz    = '0;
        lz[7] = (cur_frame[31:28] == 4'h0);
        for (int k = 6; k >= 1; k--)
            lz[k] = lz[k+1] && (cur_frame[4*k +: 4] == 4'h0);
    end
    assign blank = lz[idx];
`else
    assign blank = 1'b0;
`endif

    assign seg_hi = {cur_dot[idx], blank ? 7'h00 : code};
    assign sel_hi = 8'd1 << idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            idx       <= '0;
            frame     <= '0;
            frame_dot <= '0;
            load_pend <= 1'b1;
            sel       <= sel_off(SEL_LOW);
            seg       <= seg_off(SEG_LOW);
        end else begin
            cnt       <= tick ? '0 : cnt + CW'(1);
            load_pend <= 1'b0;
            if (tick)
                idx <= idx + 3'd1;
            if (snap) begin
                frame     <= din;
                frame_dot <= dot;
            end
            sel <= SEL_LOW ? ~sel_hi : sel_hi;
            seg <= SEG_LOW ? ~seg_hi : seg_hi;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Randomised scoreboard bench for seg_scan (SCAN_DIV = 10, active-low pins).
module tb_seg_scan;
    localparam int D = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] din = '0;
    logic [7:0]  dot = '0;
    logic [7:0]  sel;
    logic [7:0]  seg;

    seg_scan #(.CLK_FREQ(1000), .SCAN_HZ(100), .SEL_ACT_LOW(1), .SEG_ACT_LOW(1)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .dot(dot), .sel(sel), .seg(seg)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] sel; logic [7:0] seg; } exp_t;
    exp_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    int codes [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                       'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, expv);
        end
    endtask

    // Reference: edge n (1-based after release) shows digit ((n-1)/D)%8 of the
    // most recent snapshot; snapshots happen on edge 1 and every 8*D edges.
    int          n_edge;
    logic [31:0] snap_din;
    logic [7:0]  snap_dot;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_edge = 0;
            exp_q.delete();
        end else begin
            int          dig;
            logic [31:0] f;
            logic [7:0]  fd;
            logic [7:0]  s;
            exp_t        e;
            n_edge++;
            f   = (n_edge == 1) ? din : snap_din;
            fd  = (n_edge == 1) ? dot : snap_dot;
            dig = ((n_edge - 1) / D) % 8;
            s   = 8'(codes[(f >> (4 * dig)) & 32'hF]);
`ifdef SEG_SCAN_LZB_EN
            if (dig > 0 && (f >> (4 * dig)) == 0)
                s = 8'h00;
`endif
            s[7]  = fd[dig];
            e.seg = ~s;
            e.sel = ~(8'd1 << dig);
            exp_q.push_back(e);
            if (n_edge == 1 || n_edge % (8 * D) == 0) begin
                snap_din = din;
                snap_dot = dot;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n || exp_q.size() == 0) begin
            chk("sel_off", sel, 8'hFF);
            chk("seg_off", seg, 8'hFF);
        end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sel", sel, e.sel);
            chk("seg", seg, e.seg);
        end
    end

    task automatic run(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic release_rst();
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        din = 32'h1234_5678;
        dot = 8'h00;
        release_rst();
        run(16 * D);
        // Change input while digit 3 is showing; the model keeps the old frame.
        run(3 * D + 2);
        din = 32'h0000_0009;
        run(16 * D);
        din = 32'hFEDC_BA98;
        dot = 8'h05;
        run(16 * D);

        // Restart from a clean reset, then hit reset at idx=5, cnt=4.
        @(negedge clk);
        #2 rst_n = 1'b0;
        run(2);
        release_rst();
        run(5 * D + 4);
        #3 rst_n = 1'b0;
        #1;
        chk("async_sel", sel, 8'hFF);
        chk("async_seg", seg, 8'hFF);
        din = 32'h0000_0305;
        dot = 8'h00;
        run(2);
        release_rst();
        run(16 * D);
        din = 32'h0000_0000;
        dot = 8'h80;
        run(16 * D);

        for (int i = 0; i < 30; i++) begin
            int sh;
            sh  = $urandom_range(0, 8);
            din = (sh == 8) ? 32'h0 : ($urandom >> (4 * sh));
            dot = 8'($urandom);
            run($urandom_range(1, 60));
        end
        run(16 * D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Downstream display stage for the digital clock core.
- Consumes the core's 32-bit packed BCD/hex word (8 nibbles) and time-multiplexes it onto an 8-digit seven-segment display with decimal points.
- Holds a per-frame snapshot of the input so that no digit tears mid-scan.
- Drives the board's digit-select and segment pins directly.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- SCAN_HZ, 1000, digit switch rate in Hz. SCAN_DIV = CLK_FREQ/SCAN_HZ clocks per digit; must be >= 2.
- SEL_ACT_LOW, 1, 1 = digit-select pins are active-low; 0 = active-high.
- SEG_ACT_LOW, 1, 1 = segment/dp pins are active-low (common anode); 0 = active-high.

Ports:
- clk, input, 1, system clock (50 MHz).
- rst_n, input, 1, asynchronous active-low reset.
- din, input, 32, nibble k (din[4k+3:4k]) is the value for digit k; digit 0 is rightmost.
- dot, input, 8, dot[k] lights the dp of digit k.
- sel, output, 8, one-hot digit select; sel[k] enables digit k.
- seg, output, 8, seg[6:0] = g,f,e,d,c,b,a; seg[7] = dp.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-scan):
  - cnt = 0, idx = 0, frame = 0, frame_dot = 0, load_pend = 1.
  - sel = all-off (8'hFF if SEL_ACT_LOW, else 8'h00).
  - seg = all-off (8'hFF if SEG_ACT_LOW, else 8'h00).
- Tick counter:
  - cnt counts 0 .. SCAN_DIV-1 and wraps.
  - tick = (cnt == SCAN_DIV-1).
- Digit index:
  - idx (3 bits) increments on tick; 7 wraps to 0.
- Frame snapshot:
  - frame <= din and frame_dot <= dot when (tick && idx==7) || load_pend.
  - load_pend clears on the first clock after reset release, so the first frame after reset uses the live din.
  - Changes to din/dot between snapshots are not visible until the next frame.
- Decode:
  - nib = frame[4*idx +: 4].
  - Active-high gfedcba codes: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
  - dp = frame_dot[idx].
- Output registers:
  - sel and seg are registered.
  - They reflect the current idx/frame one clock later (1-cycle latency).
  - Each register is inverted per its polarity parameter.
  - Exactly one sel bit is active at any time after the first post-reset clock.
- Timing:
  - Each digit is held for exactly SCAN_DIV clocks.
  - A full frame is 8*SCAN_DIV clocks.
- Simultaneous events:
  - When tick and idx==7 coincide, the snapshot and the idx wrap occur on the same edge.
  - Digit 0 of the new frame therefore shows the new data.
- No ghosting requirement: sel and seg switch on the same edge.

Optional Feature:
- Macro: SEG_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - Digit k (k = 7..1) is blanked when nibble k and all higher nibbles of frame are zero.
  - A blanked digit drives seg all-off, but its dp is still honoured.
  - sel still scans the digit, so timing is unchanged.
  - Digit 0 is never blanked.
- Undefined: all 8 digits always display their nibble; no blanking logic is synthesised.

Decomposition:
- Package seg_pkg holds:
  - SEG_CODE constants for 0-F;
  - the SEG_OFF / SEL_OFF helpers;
  - the function seg_scan_div(CLK_FREQ, SCAN_HZ).
- One sub-module, seg_dec: combinational 4-bit nibble to 7-bit active-high segment code.
  - seg_scan instantiates it once, on the muxed nibble.
- Polarity inversion and the dp bit live in seg_scan.

Test Plan (CLK_FREQ=1000, SCAN_HZ=100 -> SCAN_DIV=10, both polarities active-low):
1. Reset check: assert rst_n=0 for 3 cycles -> sel=8'hFF, seg=8'hFF during reset. On the first clock after release, sel=8'hFE and seg shows din[3:0].
2. Full scan: din=32'h1234_5678, dot=0 -> sel walks FE,FD,FB,…,7F, 10 clocks each. seg (inverted) sequence is 7F-inv of 8=80, 7=F8, 6=82, 5=92, 4=99, 3=B0, 2=A4, 1=F9, then the frame repeats.
3. Snapshot isolation: change din to 32'h0000_0009 while idx=3 -> digits 4-7 continue showing the old values until the idx 7->0 wrap; the next frame shows the new value.
4. Dots and hex: din=32'hFEDC_BA98, dot=8'h05 -> seg[7]=0 (lit) only on digits 0 and 2. Digit 7 shows F (code 71 -> output 8E).
5. Mid-scan reset: pull rst_n low at idx=5, cnt=4 -> outputs go to all-off asynchronously. After release, the scan restarts at digit 0 with a fresh snapshot.
6. With SEG_SCAN_LZB_EN: din=32'h0000_0305 -> digits 7-3 show seg=8'hFF and digit 2 shows 3. Digit 1 shows 0 (not leading), digit 0 shows 5. With din=0, only digit 0 shows 0.
